// File: rtl/masked_rand_pkg.sv
// Shared types and LFSR constants for masked_rand_scheduler.
// The EXHAUSTED state exists only when MRS_USE_LIMIT_EN is defined.
package masked_rand_pkg;

   localparam int LFSR_W = 31;
   localparam int TAP_HI = 30;
   localparam int TAP_LO = 27;
   localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 31'h1;

   typedef enum logic [1:0] {
      ST_UNSEEDED,
      ST_WARMUP,
      ST_SERVE
`ifdef MRS_USE_LIMIT_EN
      , ST_EXHAUSTED
`endif
   } state_t;

   // An all-zero seed would lock the LFSR, so it is swapped for a fixed non-zero value.
   function automatic logic [LFSR_W-1:0] fix_seed(input logic [LFSR_W-1:0] value);
      return (value == '0) ? SEED_ZERO_SUB : value;
   endfunction

endpackage

// File: rtl/mrs_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping modulo NREQ.
module mrs_rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  win,
   output logic [IDX_W-1:0] win_idx,
   output logic             any
);

   int j;

   always_comb begin
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      j       = 0;
      for (int off = 0; off < NREQ; off++) begin
         j = int'(ptr) + off;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any     = 1'b1;
            win[j]  = 1'b1;
            win_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/masked_rand_scheduler.sv
// Seeded LFSR randomness source shared round-robin among masked gadgets.
// Define MRS_USE_LIMIT_EN to cap grants per seed and raise a sticky alarm.
module masked_rand_scheduler
   import masked_rand_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int RBITS     = 3,
   parameter int WARMUP    = 64,
   parameter int USE_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_valid,
   input  logic [30:0]       seed,
   output logic              seed_ready,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   gnt,
   output logic [RBITS-1:0]  rnd,
   output logic              ready,
   output logic              alarm
);

   localparam int PTR_W = $clog2(NREQ);
   localparam logic [7:0] WARM_LAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam state_t LOAD_STATE = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

   if (NREQ < 2 || NREQ > 8 || RBITS < 1 || RBITS > 8 ||
       WARMUP < 0 || WARMUP > 255 || USE_LIMIT < 1) begin : g_param_check
      $error("masked_rand_scheduler: parameter out of range");
   end

   state_t              state;
   logic [LFSR_W-1:0]   s;
   logic [LFSR_W-1:0]   s_one;
   logic [LFSR_W-1:0]   s_multi;
   logic [RBITS-1:0]    rnd_next;
   logic [7:0]          warm_cnt;
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    win_idx;
   logic [NREQ-1:0]     win;
   logic                any_req;
   logic                load;

   assign seed_ready = (state != ST_WARMUP);
   assign ready      = (state == ST_SERVE);
   assign load       = seed_valid && seed_ready;
   assign s_one      = {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};

   // A grant consumes RBITS consecutive feedback bits in one cycle.
   always_comb begin
      s_multi  = s;
      rnd_next = '0;
      for (int i = 0; i < RBITS; i++) begin
         rnd_next[i] = s_multi[TAP_HI] ^ s_multi[TAP_LO];
         s_multi     = {s_multi[LFSR_W-2:0], rnd_next[i]};
      end
   end

   mrs_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (req),
      .ptr     (ptr),
      .win     (win),
      .win_idx (win_idx),
      .any     (any_req)
   );

`ifdef MRS_USE_LIMIT_EN
   localparam int GCNT_W = $clog2(USE_LIMIT + 1);
   localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(USE_LIMIT - 1);
   logic [GCNT_W-1:0] gcnt;
   logic              alarm_q;
   assign alarm = alarm_q;
`else
   assign alarm = 1'b0;
`endif

   // Seed loads override everything else; otherwise warm up or serve by state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_UNSEEDED;
         s        <= SEED_ZERO_SUB;
         warm_cnt <= '0;
         ptr      <= '0;
         gnt      <= '0;
         rnd      <= '0;
`ifdef MRS_USE_LIMIT_EN
         gcnt     <= '0;
         alarm_q  <= 1'b0;
`endif
      end else begin
         gnt <= '0;
         if (load) begin
            s        <= fix_seed(seed);
            warm_cnt <= '0;
            state    <= LOAD_STATE;
`ifdef MRS_USE_LIMIT_EN
            gcnt     <= '0;
            alarm_q  <= 1'b0;
`endif
         end else begin
            case (state)
               ST_WARMUP: begin
                  s <= s_one;
                  if (warm_cnt == WARM_LAST) begin
                     warm_cnt <= '0;
                     state    <= ST_SERVE;
                  end else begin
                     warm_cnt <= warm_cnt + 8'd1;
                  end
               end
               ST_SERVE: begin
                  if (any_req) begin
                     gnt <= win;
                     rnd <= rnd_next;
                     s   <= s_multi;
                     ptr <= (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`ifdef MRS_USE_LIMIT_EN
                     gcnt <= gcnt + 1'b1;
                     if (gcnt == GCNT_LAST) begin
                        state   <= ST_EXHAUSTED;
                        alarm_q <= 1'b1;
                     end
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_masked_rand_scheduler.sv
// Directed self-checking bench for masked_rand_scheduler (default build and MRS_USE_LIMIT_EN build).
module tb_masked_rand_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        seed_valid_a, seed_ready_a, ready_a, alarm_a;
   logic [30:0] seed_a;
   logic [3:0]  req_a, gnt_a;
   logic [2:0]  rnd_a;

   logic        seed_valid_w, seed_ready_w, ready_w, alarm_w;
   logic [30:0] seed_w;
   logic [3:0]  req_w, gnt_w;
   logic [2:0]  rnd_w;

   logic        seed_valid_l, seed_ready_l, ready_l, alarm_l;
   logic [30:0] seed_l;
   logic [3:0]  req_l, gnt_l;
   logic [2:0]  rnd_l;

   int checks   = 0;
   int failures = 0;

   logic [30:0] model_s;
   logic [2:0]  exp_rnd;
   logic [2:0]  first_rnd;
   logic        rnd_varied;

   always #5 clk = ~clk;

   masked_rand_scheduler #(.NREQ(4), .RBITS(3), .WARMUP(0), .USE_LIMIT(1024)) dut_a (
      .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid_a), .seed(seed_a),
      .seed_ready(seed_ready_a), .req(req_a), .gnt(gnt_a), .rnd(rnd_a),
      .ready(ready_a), .alarm(alarm_a));

   masked_rand_scheduler #(.NREQ(4), .RBITS(3), .WARMUP(64), .USE_LIMIT(1024)) dut_w (
      .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid_w), .seed(seed_w),
      .seed_ready(seed_ready_w), .req(req_w), .gnt(gnt_w), .rnd(rnd_w),
      .ready(ready_w), .alarm(alarm_w));

   masked_rand_scheduler #(.NREQ(4), .RBITS(3), .WARMUP(0), .USE_LIMIT(5)) dut_l (
      .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid_l), .seed(seed_l),
      .seed_ready(seed_ready_l), .req(req_l), .gnt(gnt_l), .rnd(rnd_l),
      .ready(ready_l), .alarm(alarm_l));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic model_step;
      model_s = {model_s[29:0], model_s[30] ^ model_s[27]};
   endtask

   task automatic model_grant(output logic [2:0] r);
      for (int i = 0; i < 3; i++) begin
         r[i]    = model_s[30] ^ model_s[27];
         model_s = {model_s[29:0], r[i]};
      end
   endtask

   initial begin
      rst_n = 1'b0;
      seed_valid_a = 0; seed_a = '0; req_a = '0;
      seed_valid_w = 0; seed_w = '0; req_w = '0;
      seed_valid_l = 0; seed_l = '0; req_l = '0;
      tick; tick;

      check_output("rst_gnt",        gnt_a, 0);
      check_output("rst_rnd",        rnd_a, 0);
      check_output("rst_ready",      ready_a, 0);
      check_output("rst_alarm",      alarm_a, 0);
      check_output("rst_seed_ready", seed_ready_a, 1);
      check_output("rst_ready_w",    ready_w, 0);
      rst_n = 1'b1;
      tick;

      // First grant straight after seeding with no warm-up.
      seed_valid_a = 1; seed_a = 31'h4000_0000;
      tick;
      seed_valid_a = 0;
      check_output("seed_ready_up", ready_a, 1);
      check_output("seed_no_gnt",   gnt_a, 0);
      req_a = 4'b0001;
      tick;
      check_output("first_gnt", gnt_a, 4'b0001);
      check_output("first_rnd", rnd_a, 3'b001);
      req_a = 4'b0000;
      tick;
      check_output("idle_gnt",      gnt_a, 0);
      check_output("idle_rnd_hold", rnd_a, 3'b001);

      // Reset in mid-SERVE clears everything and demands a new seed.
      rst_n = 1'b0;
      tick;
      check_output("mid_rst_gnt",   gnt_a, 0);
      check_output("mid_rst_rnd",   rnd_a, 0);
      check_output("mid_rst_ready", ready_a, 0);
      check_output("mid_rst_sr",    seed_ready_a, 1);
      rst_n = 1'b1;
      req_a = 4'b1111;
      tick;
      check_output("unseeded_no_gnt", gnt_a, 0);

      // Full load: round-robin order and rnd from the reference LFSR.
      seed_valid_a = 1; seed_a = 31'h1234_5678 & 31'h7FFF_FFFF;
      model_s = 31'h1234_5678 & 31'h7FFF_FFFF;
      tick;
      seed_valid_a = 0;
      check_output("load_gnt", gnt_a, 0);
      for (int k = 0; k < 8; k++) begin
         tick;
         model_grant(exp_rnd);
         check_output($sformatf("full_gnt%0d", k), gnt_a, 32'(4'b0001 << (k % 4)));
         check_output($sformatf("full_rnd%0d", k), rnd_a, exp_rnd);
      end

      // Seed beats req in the same cycle; seed 0 behaves like seed 1.
      seed_valid_a = 1; seed_a = '0;
      tick;
      seed_valid_a = 0;
      check_output("prio_no_gnt",   gnt_a, 0);
      check_output("prio_rnd_hold", rnd_a, exp_rnd);
      model_s    = 31'h1;
      rnd_varied = 1'b0;
      first_rnd  = '0;
      for (int k = 0; k < 20; k++) begin
         tick;
         model_grant(exp_rnd);
         check_output($sformatf("zero_gnt%0d", k), gnt_a, 32'(4'b0001 << (k % 4)));
         check_output($sformatf("zero_rnd%0d", k), rnd_a, exp_rnd);
         if (k == 0) first_rnd = rnd_a;
         else if (rnd_a !== first_rnd) rnd_varied = 1'b1;
      end
      check_output("zero_not_stuck", rnd_varied, 1);
      req_a = '0;

      // WARMUP=64: ready after 64 further edges, no grants meanwhile.
      seed_valid_w = 1; seed_w = 31'h0ACE_1234; req_w = 4'b1111;
      model_s = 31'h0ACE_1234;
      tick;
      seed_valid_w = 0;
      check_output("warm_seed_ready", seed_ready_w, 0);
      for (int k = 1; k < 64; k++) begin
         tick;
         model_step;
         check_output($sformatf("warm_ready%0d", k), ready_w, 0);
         check_output($sformatf("warm_gnt%0d", k), gnt_w, 0);
      end
      tick;
      model_step;
      check_output("warm_ready_up", ready_w, 1);
      check_output("warm_last_gnt", gnt_w, 0);
      tick;
      model_grant(exp_rnd);
      check_output("warm_first_gnt", gnt_w, 4'b0001);
      check_output("warm_first_rnd", rnd_w, exp_rnd);
      seed_valid_w = 1; seed_w = 31'h7;
      tick;
      seed_valid_w = 0;
      check_output("warm_prio_gnt",   gnt_w, 0);
      check_output("warm_prio_ready", ready_w, 0);
      check_output("warm_prio_sr",    seed_ready_w, 0);
      req_w = '0;

      // Use-limit behaviour on a USE_LIMIT=5 instance.
      seed_valid_l = 1; seed_l = 31'h5; req_l = 4'b1111;
      tick;
      seed_valid_l = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
`ifdef MRS_USE_LIMIT_EN
         check_output($sformatf("lim_gnt%0d", k), gnt_l, (k < 5) ? 32'(4'b0001 << (k % 4)) : 0);
         check_output($sformatf("lim_alarm%0d", k), alarm_l, (k >= 4) ? 1 : 0);
`else
         check_output($sformatf("lim_gnt%0d", k), gnt_l, 32'(4'b0001 << (k % 4)));
         check_output($sformatf("lim_alarm%0d", k), alarm_l, 0);
`endif
      end
      seed_valid_l = 1; seed_l = 31'h9;
      tick;
      seed_valid_l = 0;
      check_output("lim_reseed_alarm", alarm_l, 0);
      check_output("lim_reseed_gnt",   gnt_l, 0);
      tick;
`ifdef MRS_USE_LIMIT_EN
      check_output("lim_resume_gnt", gnt_l, 4'b0010);
`else
      check_output("lim_resume_gnt", gnt_l, 4'b0001);
`endif
      req_l = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
